// File: rtl/aes_pkg.sv
// Shared AES MixColumns helpers: GF(2^8) constant multipliers and the iterator FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns of one 32-bit column; byte [31:24] is row 0.
// Inverse coefficients are built only when MIX_COLUMNS_ITER_INV_EN is defined.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] res
);

  logic [7:0] a0, a1, a2, a3;
  logic [31:0] fwd;

  assign {a0, a1, a2, a3} = col;

  assign fwd = {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
                gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};

`ifdef MIX_COLUMNS_ITER_INV_EN
  logic [31:0] bwd;

  assign bwd = {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0) ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1) ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2) ^ gf_mul14(a3)};

  assign res = inv ? bwd : fwd;
`else
  // Forward-only build: the select input is tied off by the parent.
  logic unused_inv;
  assign unused_inv = inv;
  assign res = fwd;
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Define MIX_COLUMNS_ITER_INV_EN to add the inv port and InvMixColumns support.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef MIX_COLUMNS_ITER_INV_EN
  ,
  input  logic         inv
`endif
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  state_t       state_q;
  logic [1:0]   cnt_q;
  logic [127:0] work_q;
  logic         inv_q;
  logic         accept;
  logic [127:0] work_next;

  logic [1:0]  idx     [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_data = work_q;

  // Column c lives at work_q[(3-c)*32 +: 32].
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      idx[g]    = cnt_q + 2'(g);
      col_in[g] = work_q[(3 - int'(idx[g])) * 32 +: 32];
    end
  end

  // NOTE: assign the default first so every path writes work_next and no latch is inferred.
  always_comb begin
    work_next = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_next[(3 - int'(idx[g])) * 32 +: 32] = col_out[g];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    mix_column_word u_word (
      .col (col_in[g]),
      .inv (inv_q),
      .res (col_out[g])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      work_q    <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // Accept happens from IDLE or from DONE on the edge the result is taken.
      state_q   <= RUN;
      cnt_q     <= 2'd0;
      work_q    <= in_data;
`ifdef MIX_COLUMNS_ITER_INV_EN
      inv_q     <= inv;
`else
      inv_q     <= 1'b0;
`endif
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          work_q <= work_next;
          cnt_q  <= cnt_q + STEP;
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: GF(2^8) matrix reference model, scoreboard
// compare process, directed vectors, back-pressure, reset abort and randomized traffic.
module tb_mix_columns_iter;

  localparam int CPC = 1;
  localparam int LAT = 4 / CPC;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         inv;

  logic         ir2, ov2, bz2, ir4, ov4, bz4;
  logic [127:0] od2, od4;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  bit prev_ov = 0;
  bit rand_ready = 0;
  logic [127:0] exp_q[$];

  mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef MIX_COLUMNS_ITER_INV_EN
    , .inv(inv)
`endif
  );

  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(1'b1), .out_data(od2), .busy(bz2)
`ifdef MIX_COLUMNS_ITER_INV_EN
    , .inv(inv)
`endif
  );

  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(1'b1), .out_data(od4), .busy(bz4)
`ifdef MIX_COLUMNS_ITER_INV_EN
    , .inv(inv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // State times the circulant matrix whose first row is co[0..3].
  function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
    logic [7:0] co [4];
    logic [7:0] r;
    logic [127:0] o;
    if (iv) co = '{8'd14, 8'd11, 8'd13, 8'd9};
    else    co = '{8'd2, 8'd3, 8'd1, 8'd1};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++)
          r = r ^ gmul(co[(j - i + 4) % 4], s[127 - 32 * c - 8 * j -: 8]);
        o[127 - 32 * c - 8 * i -: 8] = r;
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: sample at negedge, predict the handshakes of the coming posedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      prev_ov = 0;
      check_bit("reset_out_valid", out_valid, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check_bit("unexpected_output", out_valid, 1'b0);
        else check("out_data", out_data, exp_q[0]);
        if (!prev_ov) check_int("latency_edges", cyc - acc_cyc - 1, LAT);
        check_bit("in_ready_in_done", in_ready, out_ready);
      end
      if (busy) begin
        check_bit("in_ready_in_run", in_ready, 1'b0);
        check_bit("out_valid_in_run", out_valid, 1'b0);
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, inv));
        acc_cyc = cyc;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [127:0] d, input logic iv);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    inv      = iv;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check_bit("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_get(output logic [127:0] got);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        got = out_data;
        @(posedge clk);
        #1;
        return;
      end
    end
    got = '0;
    check_bit("output_timeout", 1'b0, 1'b1);
  endtask

  logic [127:0] got, got2, s, b;
  logic [127:0] st_a, st_b;
  logic [31:0]  cols_in  [3];
  logic [31:0]  cols_exp [3];
  bit           saw_ov;
  int           rise2, rise4;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inv = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    st_a = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    st_b = 128'h046681e5e0cb199a48f8d37a2806264c;
    cols_in  = '{32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6};
    cols_exp = '{32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6};

    // Pin the reference model to known AES vectors.
    check("model_fips_state", model(st_a, 1'b0), st_b);
    check("model_fips_inverse", model(st_b, 1'b1), st_a);
    for (int k = 0; k < 3; k++)
      check("model_column", model({cols_in[k], 96'h0}, 1'b0), {cols_exp[k], 96'h0});

    // Single columns in column 0.
    for (int k = 0; k < 3; k++) begin
      send({cols_in[k], 96'h0}, 1'b0);
      wait_get(got);
      check("dut_column", got, {cols_exp[k], 96'h0});
    end

    send(st_a, 1'b0);
    wait_get(got);
    check("dut_fips_state", got, st_b);

    // Back-pressure: hold the result, then hand over to the next block on the same edge.
    out_ready = 1'b0;
    send(st_a, 1'b0);
    wait_get(got);
    check("bp_first", got, st_b);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check_bit("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, st_b);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = {cols_in[0], 96'h0}; out_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_handover_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_bit("bp_handover_busy", busy, 1'b1);
    check_bit("bp_handover_ov", out_valid, 1'b0);
    wait_get(got);
    check("bp_second", got, {cols_exp[0], 96'h0});

    // Reset two cycles into a block aborts it.
    send(st_a, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_ov = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      saw_ov = saw_ov | out_valid;
    end
    check_bit("abort_no_output", saw_ov, 1'b0);
    @(posedge clk);
    #1;

    // Latency of the 2- and 4-column variants, all instances idle after reset.
    rise2 = -1; rise4 = -1;
    send(st_a, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (ov2 && rise2 < 0) begin rise2 = k; got  = od2; end
      if (ov4 && rise4 < 0) begin rise4 = k; got2 = od4; end
    end
    check_int("lat_cpc2", rise2, 2);
    check_int("lat_cpc4", rise4, 1);
    check("data_cpc2", got, st_b);
    check("data_cpc4", got2, st_b);

    // Randomized traffic with random back-pressure; the scoreboard checks every result.
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
    rand_ready = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    check_int("drain_empty", exp_q.size(), 0);

`ifdef MIX_COLUMNS_ITER_INV_EN
    send(st_b, 1'b1);
    wait_get(got);
    check("dut_inverse", got, st_a);
    for (int n = 0; n < 100; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      send(s, 1'b0);
      wait_get(got);
      send(got, 1'b1);
      wait_get(b);
      check("inv_roundtrip", b, s);
    end
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
